// File: rtl/kl8e_pkg.sv
// kl8e_pkg: shared constants for the KL8E console controller.
//   - IOT operation codes for the keyboard (KCF..KRB) and teleprinter (TFL..TLS)
//   - default device codes for the keyboard (03) and teleprinter (04)
//   - transmit sequencer state encoding
package kl8e_pkg;

  // Default IOT device codes (IR[3:8]).
  localparam logic [5:0] KBD_DEV_DEF = 6'o03;
  localparam logic [5:0] TTY_DEV_DEF = 6'o04;

  // Keyboard operations (IR[9:11]); bits combine except for KIE.
  localparam logic [2:0] KCF = 3'o0;
  localparam logic [2:0] KSF = 3'o1;
  localparam logic [2:0] KCC = 3'o2;
  localparam logic [2:0] KRS = 3'o4;
  localparam logic [2:0] KIE = 3'o5;
  localparam logic [2:0] KRB = 3'o6;

  // Teleprinter operations (IR[9:11]); bits combine except for TSK.
  localparam logic [2:0] TFL = 3'o0;
  localparam logic [2:0] TSF = 3'o1;
  localparam logic [2:0] TCF = 3'o2;
  localparam logic [2:0] TPC = 3'o4;
  localparam logic [2:0] TSK = 3'o5;
  localparam logic [2:0] TLS = 3'o6;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_STROBE    = 2'd1,
    TX_WAIT_BUSY = 2'd2,
    TX_WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/kl8e_tx_fsm.sv
// kl8e_tx_fsm: hands one character to the UART and reports completion.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         TPC decoded this cycle (ignored unless idle)
//   data_in       character to print
//   tx_rdy        UART can accept a character
//   tx_data       latched character presented to the UART
//   tx_stb        one-cycle UART load strobe
//   done          one-cycle pulse when the UART has finished the character
module kl8e_tx_fsm
  import kl8e_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       tx_rdy,
  output logic [7:0] tx_data,
  output logic       tx_stb,
  output logic       done
);

  tx_state_e  state_q, state_d;
  logic [7:0] tx_data_q, tx_data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= TX_IDLE;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
    end
  end

  // The UART is seen going busy before waiting for it to come ready again,
  // so a txRdy that has not yet dropped after the strobe is not mistaken
  // for completion.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    done      = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (start) begin
          tx_data_d = data_in;
          state_d   = TX_STROBE;
        end
      end
      TX_STROBE:    state_d = TX_WAIT_BUSY;
      TX_WAIT_BUSY: if (!tx_rdy) state_d = TX_WAIT_DONE;
      TX_WAIT_DONE: begin
        if (tx_rdy) begin
          done    = 1'b1;
          state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign tx_data = tx_data_q;
  assign tx_stb  = (state_q == TX_STROBE);

endmodule

// File: rtl/kl8e_console.sv
// kl8e_console: PDP-8 console terminal controller (KL8E equivalent).
// Decodes keyboard/teleprinter IOTs from the CPU and runs the UART handshake.
// Ports:
//   SYSCLK, RESET        clock, asynchronous active-low reset
//   ioStb/ioDev/ioOp     IOT strobe, device code, operation bits
//   acIn                 AC contents from the CPU
//   acOut/acClr/skip     IOT response, valid while ioAck is high
//   ioAck                one-cycle response pulse, one cycle after ioStb
//   irq                  interrupt request (level)
//   txData/txStb/txRdy   UART transmit handshake
//   rxData/rxRdy/rxAck   UART receive handshake
module kl8e_console
  import kl8e_pkg::*;
#(
  parameter logic [5:0] KBD_DEV     = KBD_DEV_DEF,
  parameter logic [5:0] TTY_DEV     = TTY_DEV_DEF,
  parameter logic       MARK_PARITY = 1'b1
) (
  input  logic        SYSCLK,
  input  logic        RESET,
  input  logic        ioStb,
  input  logic [5:0]  ioDev,
  input  logic [2:0]  ioOp,
  input  logic [11:0] acIn,
  output logic [11:0] acOut,
  output logic        acClr,
  output logic        skip,
  output logic        ioAck,
  output logic        irq,
  output logic [7:0]  txData,
  output logic        txStb,
  input  logic        txRdy,
  input  logic [7:0]  rxData,
  input  logic        rxRdy,
  output logic        rxAck
);

  localparam logic [7:0] PARITY_MASK = MARK_PARITY ? 8'h80 : 8'h00;

  logic        kb_flag_q, kb_flag_d;
  logic        tt_flag_q, tt_flag_d;
  logic        int_en_q,  int_en_d;
  logic [7:0]  kb_buf_q,  kb_buf_d;
  logic        rx_ack_q,  rx_ack_d;
  logic        io_ack_q,  io_ack_d;
  logic        skip_q,    skip_d;
  logic        ac_clr_q,  ac_clr_d;
  logic [11:0] ac_out_q,  ac_out_d;
  logic        irq_q,     irq_d;

  logic kb_hit, tt_hit, kb_clr, tt_clr, tt_set_op, tx_start, tx_done, rx_take;
  logic unused_ac_hi;

  // Only the low byte of AC is printed and only AC11 enables interrupts.
  assign unused_ac_hi = ^acIn[11:8];

  kl8e_tx_fsm u_tx (
    .clk     (SYSCLK),
    .rst_n   (RESET),
    .start   (tx_start),
    .data_in (acIn[7:0]),
    .tx_rdy  (txRdy),
    .tx_data (txData),
    .tx_stb  (txStb),
    .done    (tx_done)
  );

  always_ff @(posedge SYSCLK or negedge RESET) begin
    if (!RESET) begin
      kb_flag_q <= 1'b0;
      tt_flag_q <= 1'b0;
      int_en_q  <= 1'b1;
      kb_buf_q  <= 8'h00;
      rx_ack_q  <= 1'b0;
      io_ack_q  <= 1'b0;
      skip_q    <= 1'b0;
      ac_clr_q  <= 1'b0;
      ac_out_q  <= 12'o0000;
      irq_q     <= 1'b0;
    end else begin
      kb_flag_q <= kb_flag_d;
      tt_flag_q <= tt_flag_d;
      int_en_q  <= int_en_d;
      kb_buf_q  <= kb_buf_d;
      rx_ack_q  <= rx_ack_d;
      io_ack_q  <= io_ack_d;
      skip_q    <= skip_d;
      ac_clr_q  <= ac_clr_d;
      ac_out_q  <= ac_out_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    kb_hit    = ioStb && (ioDev == KBD_DEV);
    tt_hit    = ioStb && (ioDev == TTY_DEV);
    io_ack_d  = kb_hit || tt_hit;
    skip_d    = 1'b0;
    ac_clr_d  = 1'b0;
    ac_out_d  = 12'o0000;
    kb_clr    = 1'b0;
    tt_clr    = 1'b0;
    tt_set_op = 1'b0;
    tx_start  = 1'b0;
    int_en_d  = int_en_q;

    // KIE reuses the KSF+KRS code, so it is decoded as a whole word first.
    if (kb_hit) begin
      if (ioOp == KIE) begin
        int_en_d = acIn[0];
      end else begin
        if (ioOp == KCF) kb_clr = 1'b1;
        if (ioOp[0]) skip_d = kb_flag_q;
        if (ioOp[1]) begin
          ac_clr_d = 1'b1;
          kb_clr   = 1'b1;
        end
        if (ioOp[2]) ac_out_d = {4'b0000, kb_buf_q};
      end
    end

    // TSK likewise takes over the TSF+TPC code and prints nothing.
    if (tt_hit) begin
      if (ioOp == TSK) begin
        skip_d = tt_flag_q | kb_flag_q;
      end else begin
        if (ioOp == TFL) tt_set_op = 1'b1;
        if (ioOp[0]) skip_d = tt_flag_q;
        if (ioOp[1]) tt_clr = 1'b1;
        if (ioOp[2]) tx_start = 1'b1;
      end
    end

    // rxAck blocks a second capture of the character being acknowledged.
    rx_take  = rxRdy && !rx_ack_q;
    rx_ack_d = rx_take;
    kb_buf_d = rx_take ? (rxData | PARITY_MASK) : kb_buf_q;

    // Flag sets win over same-cycle clears so no event is lost.
    if (rx_take)     kb_flag_d = 1'b1;
    else if (kb_clr) kb_flag_d = 1'b0;
    else             kb_flag_d = kb_flag_q;

    if (tx_done || tt_set_op) tt_flag_d = 1'b1;
    else if (tt_clr)          tt_flag_d = 1'b0;
    else                      tt_flag_d = tt_flag_q;

    irq_d = int_en_d & (kb_flag_d | tt_flag_d);
  end

  assign acOut = ac_out_q;
  assign acClr = ac_clr_q;
  assign skip  = skip_q;
  assign ioAck = io_ack_q;
  assign irq   = irq_q;
  assign rxAck = rx_ack_q;

endmodule

// File: tb/tb_kl8e_console.sv
module tb_kl8e_console;

  localparam logic [5:0] KBD = 6'o03;
  localparam logic [5:0] TTY = 6'o04;

  logic        SYSCLK = 1'b0;
  logic        RESET;
  logic        ioStb;
  logic [5:0]  ioDev;
  logic [2:0]  ioOp;
  logic [11:0] acIn;
  logic [11:0] acOut;
  logic        acClr, skip, ioAck, irq;
  logic [7:0]  txData;
  logic        txStb, txRdy;
  logic [7:0]  rxData;
  logic        rxRdy, rxAck;

  kl8e_console dut (
    .SYSCLK(SYSCLK), .RESET(RESET), .ioStb(ioStb), .ioDev(ioDev), .ioOp(ioOp),
    .acIn(acIn), .acOut(acOut), .acClr(acClr), .skip(skip), .ioAck(ioAck),
    .irq(irq), .txData(txData), .txStb(txStb), .txRdy(txRdy), .rxData(rxData),
    .rxRdy(rxRdy), .rxAck(rxAck)
  );

  always #5 SYSCLK = ~SYSCLK;

  int n_chk = 0;
  int n_fail = 0;

  // Stimulus requested for the coming cycle.
  logic        s_rst = 1'b0, s_stb = 1'b0;
  logic [5:0]  s_dev = 6'o00;
  logic [2:0]  s_op = 3'o0;
  logic [11:0] s_ac = 12'o0000;

  // UART environment: busy countdown after a strobe, and one pending rx char.
  int          u_cnt = 0, u_lat = 4;
  logic        u_rx_pend = 1'b0;
  logic [7:0]  u_rx_data = 8'h00;

  // Reference model state and the outputs it expects in the current cycle.
  logic        m_kb = 0, m_tt = 0, m_ie = 1, m_busy = 0, m_stb = 0, m_low = 0, m_rxack = 0;
  logic [7:0]  m_buf = 0, m_txd = 0;
  logic        e_ack = 0, e_skip = 0, e_clr = 0, e_irq = 0;
  logic [11:0] e_out = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_adv();
    logic kbh, tth, kclr, tclr, tset, start, done, take;
    logic n_skip, n_clr;
    logic [11:0] n_out;
    logic n_ie, n_kb, n_tt;
    if (!s_rst) begin
      m_kb = 0; m_tt = 0; m_ie = 1; m_buf = 0; m_busy = 0; m_stb = 0; m_low = 0;
      m_txd = 0; m_rxack = 0;
      e_ack = 0; e_skip = 0; e_clr = 0; e_out = 0; e_irq = 0;
      return;
    end
    kbh = s_stb && (s_dev == KBD);
    tth = s_stb && (s_dev == TTY);
    n_skip = 0; n_clr = 0; n_out = 0; n_ie = m_ie;
    kclr = 0; tclr = 0; tset = 0; start = 0;
    if (kbh) begin
      if (s_op == 3'o5) n_ie = s_ac[0];
      else begin
        kclr = (s_op == 3'o0) || s_op[1];
        n_skip = s_op[0] ? m_kb : 1'b0;
        n_clr = s_op[1];
        n_out = s_op[2] ? {4'h0, m_buf} : 12'o0000;
      end
    end
    if (tth) begin
      if (s_op == 3'o5) n_skip = m_tt | m_kb;
      else begin
        tset = (s_op == 3'o0);
        n_skip = s_op[0] ? m_tt : 1'b0;
        tclr = s_op[1];
        start = s_op[2];
      end
    end
    take = rxRdy && !m_rxack;
    // A print finishes once the UART has gone busy and then ready again.
    done = m_busy && !m_stb && m_low && txRdy;
    n_kb = take ? 1'b1 : (kclr ? 1'b0 : m_kb);
    n_tt = (done || tset) ? 1'b1 : (tclr ? 1'b0 : m_tt);
    if (take) m_buf = rxData | 8'h80;
    m_rxack = take;
    if (start && !m_busy) begin
      m_busy = 1; m_stb = 1; m_low = 0; m_txd = s_ac[7:0];
    end else begin
      if (m_busy && !m_stb && !txRdy) m_low = 1;
      if (done) begin m_busy = 0; m_low = 0; end
      m_stb = 0;
    end
    m_kb = n_kb; m_tt = n_tt; m_ie = n_ie;
    e_ack = kbh || tth; e_skip = n_skip; e_clr = n_clr; e_out = n_out;
    e_irq = n_ie & (n_kb | n_tt);
  endtask

  // One cycle: compare outputs, drive inputs, advance model and UART, clock.
  task automatic step();
    logic o_tx, o_ra;
    check_val("ioAck", ioAck, e_ack);
    check_val("skip", skip, e_skip);
    check_val("acClr", acClr, e_clr);
    check_val("acOut", acOut, e_out);
    check_val("irq", irq, e_irq);
    check_val("txStb", txStb, m_stb);
    check_val("txData", txData, m_txd);
    check_val("rxAck", rxAck, m_rxack);
    o_tx = txStb; o_ra = rxAck;
    RESET = s_rst; ioStb = s_stb; ioDev = s_dev; ioOp = s_op; acIn = s_ac;
    txRdy = (u_cnt == 0); rxRdy = u_rx_pend; rxData = u_rx_data;
    model_adv();
    if (o_tx) u_cnt = u_lat;
    else if (u_cnt > 0) u_cnt--;
    if (o_ra) u_rx_pend = 1'b0;
    s_stb = 1'b0;
    @(posedge SYSCLK);
    @(negedge SYSCLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic iot(input logic [5:0] dev, input logic [2:0] op, input logic [11:0] ac);
    s_stb = 1'b1; s_dev = dev; s_op = op; s_ac = ac;
    step();
  endtask

  task automatic rx_inject(input logic [7:0] d);
    u_rx_pend = 1'b1; u_rx_data = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, r;
    RESET = 1'b0; ioStb = 0; ioDev = 0; ioOp = 0; acIn = 0;
    txRdy = 1; rxData = 0; rxRdy = 0;
    @(negedge SYSCLK);
    idle(3);
    check_val("rst_ioAck", ioAck, 0);
    check_val("rst_irq", irq, 0);
    check_val("rst_txData", txData, 0);
    s_rst = 1'b1;
    idle(2);

    // Flags start clear after reset.
    iot(TTY, 3'o1, 0);
    check_val("tsf_ack", ioAck, 1);
    check_val("tsf_skip0", skip, 0);
    iot(KBD, 3'o1, 0);
    check_val("ksf_ack", ioAck, 1);
    check_val("ksf_skip0", skip, 0);
    check_val("irq0", irq, 0);

    // Print 'A' with a 20-cycle busy UART.
    u_lat = 20;
    iot(TTY, 3'o6, 12'o0101);
    check_val("tls_stb", txStb, 1);
    check_val("tls_data", txData, 8'h41);
    iot(TTY, 3'o1, 0);
    check_val("tls_ttflag0", skip, 0);
    idle(30);
    check_val("print_irq", irq, 1);
    iot(TTY, 3'o1, 0);
    check_val("print_tsf", skip, 1);
    iot(TTY, 3'o2, 0);

    // Receive '1' (0x31), read back with mark parity.
    rx_inject(8'h31);
    n = 0;
    for (int i = 0; i < 4; i++) begin step(); if (rxAck) n++; end
    check_val("rx_ack_pulses", n, 1);
    check_val("rx_irq", irq, 1);
    iot(KBD, 3'o6, 0);
    check_val("krb_clr", acClr, 1);
    check_val("krb_out", acOut, 12'o0261);
    iot(KBD, 3'o1, 0);
    check_val("krb_kbflag", skip, 0);

    // Interrupt enable control.
    iot(KBD, 3'o5, 12'o0000);
    rx_inject(8'h55);
    idle(4);
    check_val("kie0_irq", irq, 0);
    iot(KBD, 3'o1, 0);
    check_val("kie0_kbflag", skip, 1);
    iot(KBD, 3'o5, 12'o0001);
    check_val("kie1_irq", irq, 1);
    iot(KBD, 3'o2, 0);
    check_val("kcc_irq", irq, 0);

    // Second TLS while the first character is still printing.
    u_lat = 10;
    iot(TTY, 3'o6, 12'o0101);
    idle(3);
    iot(TTY, 3'o6, 12'o0102);
    check_val("tls2_stb", txStb, 0);
    check_val("tls2_data", txData, 8'h41);
    iot(TTY, 3'o1, 0);
    check_val("tls2_ttflag", skip, 0);
    k = 0; n = 0;
    while (!irq && k < 40) begin step(); if (txStb) n++; k++; end
    check_val("tls2_done", irq, 1);
    check_val("tls2_no_stb", n, 0);
    check_val("tls2_keep", txData, 8'h41);
    iot(TTY, 3'o2, 0);

    // KCC in the same cycle as a character arrival: set wins.
    rx_inject(8'h07);
    iot(KBD, 3'o2, 0);
    check_val("kcc_race_clr", acClr, 1);
    iot(KBD, 3'o1, 0);
    check_val("kcc_race_flag", skip, 1);
    iot(KBD, 3'o4, 0);
    check_val("kcc_race_buf", acOut, 12'o0207);
    iot(KBD, 3'o0, 0);

    // Reset in the middle of a print, with a character waiting in the UART.
    u_lat = 15;
    iot(TTY, 3'o6, 12'o0122);
    idle(4);
    rx_inject(8'h44);
    s_rst = 1'b0;
    idle(3);
    s_rst = 1'b1;
    n = 0;
    for (int i = 0; i < 25; i++) begin step(); if (txStb) n++; end
    check_val("rst_no_stb", n, 0);
    iot(KBD, 3'o1, 0);
    check_val("rst_rx_after", skip, 1);
    iot(TTY, 3'o6, 12'o0103);
    check_val("rst_tls_stb", txStb, 1);
    check_val("rst_tls_data", txData, 8'h43);
    idle(30);
    iot(TTY, 3'o2, 0);
    iot(KBD, 3'o0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      u_lat = $urandom_range(1, 8);
      if (!u_rx_pend && $urandom_range(0, 9) == 0) rx_inject(8'($urandom_range(0, 255)));
      s_rst = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 3);
        s_dev = (r == 0) ? KBD : (r == 1) ? TTY : (r == 2) ? TTY : 6'($urandom_range(0, 63));
        s_op = 3'($urandom_range(0, 7));
        s_ac = 12'($urandom);
        s_stb = 1'b1;
      end
      step();
    end
    s_rst = 1'b1;
    idle(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
